// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the serial pattern detector:
//   det_state_e  - control FSM states (FILL / ARMED / HIT)
//   MAX_PAT_W    - largest supported pattern length
//   FILL_W       - width of the window fill counter, sized for MAX_PAT_W
//   alt_pattern  - builds the alternating 1010... reset pattern
// -----------------------------------------------------------------------------
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,  // fewer than PAT_W valid bits in the window
    ST_ARMED = 2'd1,  // window full, waiting for a matching bit
    ST_HIT   = 2'd2   // a match was registered on the previous edge
  } det_state_e;

  localparam int MAX_PAT_W = 16;

  // Fill counts 0..PAT_W inclusive; sizing for the largest legal PAT_W
  // lets one constant serve every instance.
  localparam int FILL_W = $clog2(MAX_PAT_W + 1);

  // Alternating pattern with the first-received bit (MSB of the pattern) = 1.
  // The result sits in the low pat_w bits.
  function automatic logic [MAX_PAT_W-1:0] alt_pattern(input int pat_w);
    logic [MAX_PAT_W-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_PAT_W; i++) begin
      if (i < pat_w) p = {p[MAX_PAT_W-2:0], ~i[0]};
    end
    return p;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset (count -> 0)
//   inc   - add one on this edge unless already saturated
//   clr   - synchronous clear, priority over inc
//   count - current count
//   sat   - high while count is all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !sat) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign sat   = &r_count;

endmodule

// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
// Serial bit-pattern detector with configurable pattern, overlapping or
// non-overlapping detection, and a saturating match counter.
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst          - asynchronous active-high reset
//   in_valid     - in_bit is accepted only when high
//   in_bit       - serial data bit
//   cfg_load     - latch cfg_pattern / cfg_overlap and clear the window;
//                  a bit presented on the same edge is discarded
//   cfg_pattern  - target pattern, MSB is the first bit received
//   cfg_overlap  - 1: overlapping detection, 0: non-overlapping
//   cnt_clr      - synchronous clear of match_count (wins over a match)
//   detected     - one-cycle pulse the cycle after the final pattern bit
//   match_count  - saturating count of matches
//   count_sat    - high while match_count is all-ones
// -----------------------------------------------------------------------------
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             detected,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam logic [MAX_PAT_W-1:0] RST_PAT_FULL = alt_pattern(PAT_W);
  localparam logic [PAT_W-1:0]     RST_PAT      = RST_PAT_FULL[PAT_W-1:0];
  localparam logic [FILL_W-1:0]    FILL_FULL    = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  r_pattern;
  logic              r_overlap;
  det_state_e        r_state;

  logic [PAT_W-1:0]  w_next_win;
  logic [FILL_W-1:0] w_next_fill;
  logic              w_accept;
  logic              w_match;
  det_state_e        w_next_state;

  // A bit presented together with cfg_load belongs to the old configuration
  // and is dropped.
  assign w_accept    = in_valid & ~cfg_load;
  assign w_next_win  = {r_hist[PAT_W-2:0], in_bit};
  assign w_next_fill = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
  assign w_match     = w_accept && (w_next_fill == FILL_FULL) &&
                       (w_next_win == r_pattern);

  // Window and configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= RST_PAT;
      r_overlap <= 1'b1;
    end else if (cfg_load) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= cfg_pattern;
      r_overlap <= cfg_overlap;
    end else if (in_valid) begin
      r_hist <= w_next_win;
      // Non-overlapping mode restarts the window after a match; hist keeps
      // shifting but is ignored until fill reaches PAT_W again.
      r_fill <= (w_match && !r_overlap) ? '0 : w_next_fill;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_next_state;
  end

  // FSM: next-state logic. HIT lasts one cycle; on an idle edge it falls back
  // to whichever of FILL/ARMED the (unchanged) fill count implies.
  always_comb begin
    // NOTE: default assignment first so no path through this block leaves
    // w_next_state unassigned, which would infer a latch.
    w_next_state = r_state;
    if (cfg_load) begin
      w_next_state = ST_FILL;
    end else if (w_match) begin
      w_next_state = ST_HIT;
    end else if (in_valid) begin
      w_next_state = (w_next_fill == FILL_FULL) ? ST_ARMED : ST_FILL;
    end else if (r_state == ST_HIT) begin
      w_next_state = (r_fill == FILL_FULL) ? ST_ARMED : ST_FILL;
    end
  end

  // FSM: output logic, decoded straight from the state register.
  always_comb begin
    detected = (r_state == ST_HIT);
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_match),
    .clr   (cnt_clr),
    .count (match_count),
    .sat   (count_sat)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_detector
// Scoreboard bench: the driver applies one edge of stimulus at a time, runs a
// bit-queue reference model and pushes the expected post-edge outputs; an
// independent monitor pops and compares them every cycle.
// -----------------------------------------------------------------------------
module tb_seq_pattern_detector;

  localparam int PAT_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int RST_PAT = 'b1010;  // alternating, first bit 1

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             detected;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .detected    (detected),
    .match_count (match_count),
    .count_sat   (count_sat)
  );

  typedef struct {
    logic det;
    int   cnt;
    logic sat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the accepted bits since the window was last cleared.
  int   m_win[$];
  int   m_pat;
  bit   m_ovl;
  int   m_cnt;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one edge of stimulus and push the outputs expected after it.
  task automatic step(input bit r, input bit ld, input int pat, input bit ovl,
                      input bit v, input bit b, input bit c);
    exp_t e;
    bit   match;
    int   val;
    @(negedge clk);
    #1;
    rst         = r;
    cfg_load    = ld;
    cfg_pattern = pat[PAT_W-1:0];
    cfg_overlap = ovl;
    in_valid    = v;
    in_bit      = b;
    cnt_clr     = c;
    match = 1'b0;
    if (r) begin
      m_win.delete();
      m_pat = RST_PAT;
      m_ovl = 1'b1;
      m_cnt = 0;
    end else begin
      if (ld) begin
        m_win.delete();
        m_pat = pat & ((1 << PAT_W) - 1);
        m_ovl = ovl;
      end else if (v) begin
        m_win.push_back(int'(b));
        if (m_win.size() > PAT_W) void'(m_win.pop_front());
        if (m_win.size() == PAT_W) begin
          val = 0;
          foreach (m_win[i]) val = (val << 1) | m_win[i];
          match = (val == m_pat);
        end
        if (match && !m_ovl) m_win.delete();
      end
      if (c)                           m_cnt = 0;
      else if (match && m_cnt < CNT_MAX) m_cnt++;
    end
    e.det = match;
    e.cnt = m_cnt;
    e.sat = (m_cnt == CNT_MAX);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Load a configuration and clear the counter on the same edge.
  task automatic configure(input int pat, input bit ovl);
    step(1'b0, 1'b1, pat, ovl, 1'b0, 1'b0, 1'b1);
  endtask

  // '1'/'0' send a valid bit, '-' is an idle edge.
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "-") idle();
      else step(1'b0, 1'b0, 0, 1'b0, 1'b1, s[i] == "1", 1'b0);
    end
  endtask

  // Monitor: compare once per cycle, well clear of both edges.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("detected", 32'(detected), 32'(e.det));
        check("match_count", 32'(match_count), e.cnt);
        check("count_sat", 32'(count_sat), 32'(e.sat));
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; cnt_clr = 1'b0;
    m_pat = RST_PAT; m_ovl = 1'b1; m_cnt = 0;

    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // Reset configuration detects 1010 with overlap.
    send("101010");

    configure('b1010, 1'b1);
    send("101010");
    configure('b1010, 1'b0);
    send("101010");
    configure('b1010, 1'b0);
    send("10101010");

    // Gaps inside a partial match.
    configure('b1010, 1'b1);
    send("10---10--");

    // Reset mid-pattern discards the partial match.
    configure('b1010, 1'b1);
    send("101");
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send("0");
    send("1010-");

    // Saturation, then clear coinciding with the fifth match.
    configure('b1010, 1'b1);
    send("10101010101");
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();

    // cfg_load on the final bit of 1010 drops it; new pattern then matches.
    configure('b1010, 1'b1);
    send("101");
    step(1'b0, 1'b1, 'b0110, 1'b1, 1'b1, 1'b0, 1'b0);
    send("0110--");

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 49) == 0,
           int'($urandom_range(0, (1 << PAT_W) - 1)),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0);
    end
    idle();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
